// File: rtl/hw2_pipe_arbiter.sv
// Two-requester round-robin front end for hw2_pipe: issues at most one op per cycle,
// tags each op with its owner through PIPE_LAT+1 stages and pulses the result back to that owner.
module hw2_pipe_arbiter #(
  parameter int PIPE_LAT = 2,
  parameter int CNT_W    = 16
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [7:0]       req0_a,
  input  logic [7:0]       req0_b,
  input  logic [7:0]       req0_c,
  input  logic             req0_s,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [7:0]       req1_a,
  input  logic [7:0]       req1_b,
  input  logic [7:0]       req1_c,
  input  logic             req1_s,
  input  logic             flush,
  output logic [7:0]       pipe_a,
  output logic [7:0]       pipe_b,
  output logic [7:0]       pipe_c,
  output logic             pipe_s,
  input  logic [15:0]      pipe_d,
  output logic             res0_valid,
  output logic             res1_valid,
  output logic [15:0]      res_d,
  output logic             busy,
  output logic [CNT_W-1:0] ops_cnt
);

  logic              rr_q, rr_d;
  logic              grant_vld, grant_id;
  logic [PIPE_LAT:0] tag_vld_q, tag_vld_d;
  logic [PIPE_LAT:0] tag_own_q, tag_own_d;
  logic [7:0]        pipe_a_q, pipe_a_d, pipe_b_q, pipe_b_d, pipe_c_q, pipe_c_d;
  logic              pipe_s_q, pipe_s_d;
  logic              res0_vld_q, res0_vld_d, res1_vld_q, res1_vld_d;
  logic [15:0]       res_d_q;
  logic [CNT_W-1:0]  ops_cnt_q, ops_cnt_d;

  // rr only breaks ties; a lone valid requester is always granted.
  always_comb begin
    grant_vld = !reset && !flush && (req0_valid || req1_valid);
    grant_id  = (req0_valid && req1_valid) ? rr_q : req1_valid;
    rr_d      = grant_vld ? !grant_id : rr_q;
    ops_cnt_d = grant_vld ? ops_cnt_q + CNT_W'(1) : ops_cnt_q;

    pipe_a_d = 8'h00;
    pipe_b_d = 8'h00;
    pipe_c_d = 8'h00;
    pipe_s_d = 1'b0;
    if (grant_vld) begin
      pipe_a_d = grant_id ? req1_a : req0_a;
      pipe_b_d = grant_id ? req1_b : req0_b;
      pipe_c_d = grant_id ? req1_c : req0_c;
      pipe_s_d = grant_id ? req1_s : req0_s;
    end

    tag_vld_d = {tag_vld_q[PIPE_LAT-1:0], grant_vld};
    tag_own_d = {tag_own_q[PIPE_LAT-1:0], grant_id};
    if (flush) tag_vld_d = '0;

    res0_vld_d = !flush && tag_vld_q[PIPE_LAT] && !tag_own_q[PIPE_LAT];
    res1_vld_d = !flush && tag_vld_q[PIPE_LAT] &&  tag_own_q[PIPE_LAT];
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      rr_q       <= 1'b0;
      ops_cnt_q  <= '0;
      pipe_a_q   <= 8'h00;
      pipe_b_q   <= 8'h00;
      pipe_c_q   <= 8'h00;
      pipe_s_q   <= 1'b0;
      tag_vld_q  <= '0;
      tag_own_q  <= '0;
      res0_vld_q <= 1'b0;
      res1_vld_q <= 1'b0;
      res_d_q    <= 16'h0000;
    end else begin
      rr_q       <= rr_d;
      ops_cnt_q  <= ops_cnt_d;
      pipe_a_q   <= pipe_a_d;
      pipe_b_q   <= pipe_b_d;
      pipe_c_q   <= pipe_c_d;
      pipe_s_q   <= pipe_s_d;
      tag_vld_q  <= tag_vld_d;
      tag_own_q  <= tag_own_d;
      res0_vld_q <= res0_vld_d;
      res1_vld_q <= res1_vld_d;
      res_d_q    <= pipe_d;
    end
  end

  assign req0_ready = grant_vld && !grant_id;
  assign req1_ready = grant_vld &&  grant_id;
  assign pipe_a     = pipe_a_q;
  assign pipe_b     = pipe_b_q;
  assign pipe_c     = pipe_c_q;
  assign pipe_s     = pipe_s_q;
  assign res0_valid = res0_vld_q;
  assign res1_valid = res1_vld_q;
  assign res_d      = res_d_q;
  assign busy       = (|tag_vld_q) || res0_vld_q || res1_vld_q;
  assign ops_cnt    = ops_cnt_q;

endmodule

// File: tb/tb_hw2_pipe_arbiter.sv
// Bench for hw2_pipe_arbiter: vector table, directed corner sequences and a random run
// against a queue-based model of expected results (plus a narrow-counter second instance).
module tb_hw2_pipe_arbiter;
  localparam int PL = 2;

  logic CLK = 1'b0;
  logic reset = 1'b1;
  always #5 CLK = ~CLK;

  logic       req0_valid = 0, req1_valid = 0, flush = 0;
  logic [7:0] req0_a = 0, req0_b = 0, req0_c = 0, req1_a = 0, req1_b = 0, req1_c = 0;
  logic       req0_s = 0, req1_s = 0;
  logic       req0_ready, req1_ready, pipe_s, res0_valid, res1_valid, busy;
  logic [7:0] pipe_a, pipe_b, pipe_c;
  logic [15:0] pipe_d, res_d, ops_cnt;
  logic       w_req0_ready, w_req1_ready, w_pipe_s, w_res0_valid, w_res1_valid, w_busy;
  logic [7:0] w_pipe_a, w_pipe_b, w_pipe_c;
  logic [15:0] w_res_d;
  logic [3:0] w_ops_cnt;

  hw2_pipe_arbiter #(.PIPE_LAT(PL), .CNT_W(16)) dut (
    .CLK(CLK), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_c(req0_c), .req0_s(req0_s),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_c(req1_c), .req1_s(req1_s),
    .flush(flush), .pipe_a(pipe_a), .pipe_b(pipe_b), .pipe_c(pipe_c), .pipe_s(pipe_s),
    .pipe_d(pipe_d), .res0_valid(res0_valid), .res1_valid(res1_valid), .res_d(res_d),
    .busy(busy), .ops_cnt(ops_cnt));

  hw2_pipe_arbiter #(.PIPE_LAT(PL), .CNT_W(4)) dut_w (
    .CLK(CLK), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(w_req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_c(req0_c), .req0_s(req0_s),
    .req1_valid(req1_valid), .req1_ready(w_req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_c(req1_c), .req1_s(req1_s),
    .flush(flush), .pipe_a(w_pipe_a), .pipe_b(w_pipe_b), .pipe_c(w_pipe_c), .pipe_s(w_pipe_s),
    .pipe_d(pipe_d), .res0_valid(w_res0_valid), .res1_valid(w_res1_valid), .res_d(w_res_d),
    .busy(w_busy), .ops_cnt(w_ops_cnt));

  function automatic logic [15:0] ref_d(input logic [7:0] a, b, c, input logic s);
    int t;
    t = s ? (int'(a) + int'(b)) : (int'(a) - int'(b));
    t = (t + 512) % 512;
    return 16'((t * int'(c)) % 65536);
  endfunction

  // Stand-in for hw2_pipe: result appears PL edges after the operands.
  logic [15:0] psh [PL];
  always @(posedge CLK) begin
    psh[0] <= ref_d(pipe_a, pipe_b, pipe_c, pipe_s);
    for (int k = 1; k < PL; k++) psh[k] <= psh[k-1];
  end
  assign pipe_d = psh[PL-1];

  typedef struct { int due; logic own; logic [15:0] d; } ent_t;
  ent_t q[$];
  logic glog[$];
  int   n_edge = 0, m_cnt = 0, tests = 0, fails = 0;
  logic m_rr = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Called at a negedge with inputs applied; checks, crosses one posedge, returns at next negedge.
  task automatic cycle();
    logic eg, eid, x0, x1, eb;
    logic [15:0] xd;
    #1;
    eg  = !flush && (req0_valid || req1_valid);
    eid = (req0_valid && req1_valid) ? m_rr : req1_valid;
    chk("req0_ready", req0_ready, eg && !eid);
    chk("req1_ready", req1_ready, eg && eid);
    chk("w_req0_ready", w_req0_ready, eg && !eid);
    x0 = 0; x1 = 0; eb = 0; xd = 0;
    foreach (q[i]) begin
      eb = 1;
      if (q[i].due == n_edge) begin
        if (q[i].own) x1 = 1; else x0 = 1;
        xd = q[i].d;
      end
    end
    chk("res0_valid", res0_valid, x0);
    chk("res1_valid", res1_valid, x1);
    chk("w_res1_valid", w_res1_valid, x1);
    if (x0 || x1) chk("res_d", res_d, xd);
    chk("busy", busy, eb);
    chk("ops_cnt", ops_cnt, m_cnt % 65536);
    chk("w_ops_cnt", w_ops_cnt, m_cnt % 16);
    @(posedge CLK);
    n_edge++;
    if (flush) q.delete();
    else begin
      q = q.find(x) with (x.due >= n_edge);
      if (eg) begin
        if (eid) q.push_back('{n_edge + PL + 1, 1'b1, ref_d(req1_a, req1_b, req1_c, req1_s)});
        else     q.push_back('{n_edge + PL + 1, 1'b0, ref_d(req0_a, req0_b, req0_c, req0_s)});
        m_cnt++;
        m_rr = !eid;
        glog.push_back(eid);
      end
    end
    @(negedge CLK);
  endtask

  task automatic do_reset();
    reset = 1;
    q.delete();
    m_rr = 0;
    m_cnt = 0;
    @(posedge CLK);
    @(negedge CLK);
    reset = 0;
  endtask

  task automatic set_req(input logic who, input logic [7:0] a, b, c, input logic s);
    if (who) begin req1_a = a; req1_b = b; req1_c = c; req1_s = s; end
    else     begin req0_a = a; req0_b = b; req0_c = c; req0_s = s; end
  endtask

  typedef struct { logic [7:0] a, b, c; logic s; logic own; logic [15:0] exp_d; } vec_t;
  vec_t tbl[6];
  int   pulses, gsz;
  logic acc0, acc1;

  initial begin
    tbl[0] = '{8'h10, 8'h05, 8'h03, 1'b1, 1'b0, 16'h003F};
    tbl[1] = '{8'h05, 8'h10, 8'h02, 1'b0, 1'b1, 16'h03EA};
    tbl[2] = '{8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 16'h0000};
    tbl[3] = '{8'hFF, 8'hFF, 8'hFF, 1'b1, 1'b0, 16'hFC02};
    tbl[4] = '{8'h00, 8'hFF, 8'hFF, 1'b0, 1'b1, 16'hFFFF};
    tbl[5] = '{8'h80, 8'h80, 8'h10, 1'b1, 1'b0, 16'h1000};

    #12;
    @(negedge CLK);
    reset = 0;
    #1;
    chk("rst_pipe_a", pipe_a, 0);
    chk("rst_res_d", res_d, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ops_cnt", ops_cnt, 0);

    for (int i = 0; i < 6; i++) begin
      set_req(tbl[i].own, tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].s);
      req0_valid = !tbl[i].own;
      req1_valid = tbl[i].own;
      cycle();
      req0_valid = 0; req1_valid = 0;
      if (i == 0) chk("first_ops_cnt", ops_cnt, 1);
      repeat (3) cycle();
      chk("tbl_res_d", res_d, tbl[i].exp_d);
      chk("tbl_res0", res0_valid, !tbl[i].own);
      chk("tbl_res1", res1_valid, tbl[i].own);
      cycle();
    end

    // Contention straight after reset: strict alternation starting at requester 0.
    do_reset();
    glog.delete();
    set_req(0, 8'h21, 8'h02, 8'h05, 1'b1);
    set_req(1, 8'h07, 8'h09, 8'h11, 1'b0);
    req0_valid = 1; req1_valid = 1;
    repeat (6) cycle();
    req0_valid = 0; req1_valid = 0;
    chk("contend_cnt", glog.size(), 6);
    for (int i = 0; i < 6; i++) chk("contend_grant", glog[i], i % 2);
    repeat (5) cycle();

    // Flush one cycle after the second accept kills both results.
    set_req(0, 8'h33, 8'h11, 8'h02, 1'b1);
    req0_valid = 1;
    cycle();
    req0_valid = 0;
    set_req(1, 8'h44, 8'h04, 8'h03, 1'b0);
    req1_valid = 1;
    cycle();
    req1_valid = 0;
    flush = 1; req0_valid = 1;
    #1;
    chk("flush_ready", req0_ready, 0);
    cycle();
    flush = 0; req0_valid = 0;
    pulses = 0;
    repeat (5) begin
      cycle();
      pulses += int'(res0_valid) + int'(res1_valid);
    end
    chk("flush_pulses", pulses, 0);
    set_req(1, 8'h05, 8'h10, 8'h02, 1'b0);
    req1_valid = 1;
    cycle();
    req1_valid = 0;
    repeat (3) cycle();
    chk("post_flush_res1", res1_valid, 1);
    chk("post_flush_res_d", res_d, 16'h03EA);
    cycle();

    // Asynchronous reset with two ops in flight.
    set_req(0, 8'h11, 8'h01, 8'h01, 1'b1);
    req0_valid = 1;
    cycle();
    set_req(0, 8'h12, 8'h01, 8'h01, 1'b1);
    cycle();
    #2 reset = 1;
    #1;
    chk("amid_pipe_a", pipe_a, 0);
    chk("amid_busy", busy, 0);
    chk("amid_ops_cnt", ops_cnt, 0);
    chk("amid_ready", req0_ready, 0);
    chk("amid_res0", res0_valid, 0);
    q.delete(); m_rr = 0; m_cnt = 0;
    @(negedge CLK);
    reset = 0;
    req0_valid = 0;
    repeat (5) cycle();
    req0_valid = 1; req1_valid = 1;
    #1;
    chk("post_rst_r0", req0_ready, 1);
    chk("post_rst_r1", req1_ready, 0);
    cycle();
    req0_valid = 0; req1_valid = 0;
    repeat (5) cycle();

    // Narrow counter wraps 15 -> 0 -> 1.
    do_reset();
    req0_valid = 1;
    for (int i = 0; i < 17; i++) begin
      set_req(0, 8'(i), 8'h03, 8'h07, 1'(i % 2));
      cycle();
      if (i == 14) chk("wrap_15", w_ops_cnt, 15);
      if (i == 15) chk("wrap_0", w_ops_cnt, 0);
      if (i == 16) chk("wrap_1", w_ops_cnt, 1);
    end
    req0_valid = 0;
    repeat (5) cycle();

    // Random traffic; operands stay put while a request waits.
    acc0 = 1; acc1 = 1;
    for (int n = 0; n < 1500; n++) begin
      if (!req0_valid || acc0) begin
        req0_valid = 1'($urandom_range(0, 1));
        set_req(0, 8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
      end
      if (!req1_valid || acc1) begin
        req1_valid = 1'($urandom_range(0, 1));
        set_req(1, 8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
      end
      flush = ($urandom_range(0, 19) == 0);
      gsz = glog.size();
      cycle();
      acc0 = (glog.size() > gsz) && (glog[glog.size()-1] == 1'b0);
      acc1 = (glog.size() > gsz) && (glog[glog.size()-1] == 1'b1);
    end
    req0_valid = 0; req1_valid = 0; flush = 0;
    repeat (6) cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
